// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the default operand width.
package seq_divider_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        SUB   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DIV_N = 8;

endpackage

// File: rtl/seq_divider_ctrl.sv
// Control FSM for the restoring divider. It sequences LOAD, SHIFT/SUB pairs and
// DONE, and emits the strobes that steer the datapath held in seq_divider.
module seq_divider_ctrl
    import seq_divider_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic eqz,
    input  logic tneg,
    input  logic cnt_last,
    output logic load_en,
    output logic zero_wr,
    output logic shift_en,
    output logic sub_en,
    output logic a_wr,
    output logic res_wr,
    output logic busy,
    output logic done
);

    state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (eqz) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: state <= SUB;
                SUB: begin
                    if (cnt_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= SHIFT;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes act on the edge that leaves the current state.
    assign load_en  = (state == IDLE) && start;
    assign zero_wr  = (state == LOAD) && eqz;
    assign shift_en = (state == SHIFT);
    assign sub_en   = (state == SUB);
    assign a_wr     = (state == SUB) && !tneg;
    assign res_wr   = (state == SUB) && cnt_last;

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per SHIFT/SUB pair,
// N iterations, with a divide-by-zero shortcut straight from LOAD to DONE.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CNT_W = $clog2(N + 1);

    logic [N:0]       a;
    logic [N-1:0]     q;
    logic [N-1:0]     m;
    logic [CNT_W-1:0] cnt;
    logic [N:0]       t;
    logic             tneg;
    logic             eqz;
    logic             cnt_last;
    logic             load_en;
    logic             zero_wr;
    logic             shift_en;
    logic             sub_en;
    logic             a_wr;
    logic             res_wr;

    assign t        = a - {1'b0, m};
    assign tneg     = t[N];
    assign eqz      = (m == '0);
    assign cnt_last = (cnt == CNT_W'(1));

    seq_divider_ctrl u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .eqz      (eqz),
        .tneg     (tneg),
        .cnt_last (cnt_last),
        .load_en  (load_en),
        .zero_wr  (zero_wr),
        .shift_en (shift_en),
        .sub_en   (sub_en),
        .a_wr     (a_wr),
        .res_wr   (res_wr),
        .busy     (busy),
        .done     (done)
    );

    // Operands are captured on the start edge so later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a   <= '0;
            q   <= '0;
            m   <= '0;
            cnt <= '0;
        end else if (load_en) begin
            a   <= '0;
            q   <= dividend;
            m   <= divisor;
            cnt <= CNT_W'(N);
        end else if (shift_en) begin
            {a, q} <= {a[N-1:0], q, 1'b0};
        end else if (sub_en) begin
            cnt  <= cnt - CNT_W'(1);
            q[0] <= !tneg;
            if (a_wr) begin
                a <= t;
            end
        end
    end

    // On the final SUB the last quotient bit and restored remainder are
    // folded in directly, so the results are valid in the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (zero_wr) begin
            quotient    <= '1;
            remainder   <= q;
            div_by_zero <= 1'b1;
        end else if (res_wr) begin
            quotient    <= {q[N-1:1], !tneg};
            remainder   <= tneg ? a[N-1:0] : t[N-1:0];
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider at N=8: results, latency,
// busy/done behaviour, start-while-busy rejection and asynchronous reset.
module tb_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int compared   = 0;
    int mismatched = 0;

    seq_divider #(.N(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge while the DUT is idle; returns at a falling
    // edge in the IDLE cycle that follows DONE.
    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er, input logic ez,
                           input int lat, input bit disturb);
        int got;
        got      = 0;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk({tag, "_busy"}, busy, 1);
                start    = 1'b0;
                dividend = ~a;
                divisor  = ~b;
            end
            if (disturb && c == 5) begin
                start    = 1'b1;
                dividend = 8'd17;
                divisor  = 8'd5;
            end
            if (disturb && c == 6) start = 1'b0;
            if (done) begin
                got = c;
                break;
            end
        end
        chk({tag, "_lat"}, got, lat);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dbz"}, div_by_zero, ez);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int activity;
        int got;
        logic [7:0] ra, rb;

        rst_n    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_div("d100_7",  8'd100, 8'd7, 8'd14,  8'd2,  1'b0, 18, 1'b0);
        run_div("d255_1",  8'd255, 8'd1, 8'd255, 8'd0,  1'b0, 18, 1'b0);
        run_div("d5_9",    8'd5,   8'd9, 8'd0,   8'd5,  1'b0, 18, 1'b0);
        run_div("d42_0",   8'd42,  8'd0, 8'd255, 8'd42, 1'b1, 2,  1'b0);
        run_div("d100_7b", 8'd100, 8'd7, 8'd14,  8'd2,  1'b0, 18, 1'b0);
        run_div("busy_ign", 8'd200, 8'd3, 8'd66, 8'd2,  1'b0, 18, 1'b1);

        activity = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) activity++;
        end
        chk("busy_ign_extra", activity, 0);
        chk("hold_q", quotient, 66);
        chk("hold_r", remainder, 2);

        // Reset during the SUB of iteration 4 (cycle 9 after the start edge).
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_q", quotient, 0);
        chk("mid_rst_r", remainder, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        activity = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) activity++;
        end
        chk("post_rst_quiet", activity, 0);
        run_div("post_rst", 8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 18, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra       = 8'($urandom_range(255, 0));
            rb       = 8'($urandom_range(255, 1));
            start    = 1'b1;
            dividend = ra;
            divisor  = rb;
            @(posedge clk);
            got = 0;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                start = 1'b0;
                if (done) begin
                    got = c;
                    break;
                end
            end
            chk("sweep_lat", got, 18);
            chk("sweep_eq", 32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
            chk("sweep_lt", 32'(remainder < rb), 1);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
